// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the UART transmitter and receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with a combinational read port (head word always visible).
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART: FIFO-fed transmitter and 16x-oversampling receiver on one baud generator.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 100000000,
    parameter int BAUD          = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr_en,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int RX_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        return (PARITY == PARITY_ODD) ? ~(^word) : ^word;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       sub_cnt;
    logic             tick16;
    logic             tx_tick;

    assign tick16  = (div_cnt == DIV_W'(RX_DIV - 1));
    assign tx_tick = tick16 && (sub_cnt == 4'd15);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sub_cnt <= '0;
        end else if (tick16) begin
            div_cnt <= '0;
            sub_cnt <= sub_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] fifo_data;
    logic [DATA_BITS-1:0] tx_word;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BIT_W-1:0]     tx_bit;
    logic                 tx_stop_cnt;
    logic                 last_stop;
    logic                 fifo_empty;
    logic                 fifo_pop;

    assign last_stop = (tx_stop_cnt == 1'(STOP_BITS - 1));
    // The next word is taken either from idle or straight out of the last stop bit, so queued frames abut.
    assign fifo_pop  = tx_tick && !fifo_empty &&
                       ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && last_stop));
    assign tx_busy   = (tx_state != TX_IDLE) || !fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk_in),
        .rst_n   (rst_n),
        .wr_en   (tx_wr_en),
        .wr_data (tx_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_data),
        .full    (tx_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx          <= 1'b1;
            tx_bit      <= '0;
            tx_stop_cnt <= 1'b0;
        end else if (tx_tick) begin
            case (tx_state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_word  <= fifo_data;
                        tx_shift <= fifo_data;
                        tx       <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    tx       <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= BIT_W'(1);
                    tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bit == BIT_W'(DATA_BITS)) begin
                        if (PARITY != PARITY_NONE) begin
                            tx       <= parity_bit(tx_word);
                            tx_state <= TX_PARITY;
                        end else begin
                            tx          <= 1'b1;
                            tx_stop_cnt <= 1'b0;
                            tx_state    <= TX_STOP;
                        end
                    end else begin
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end
                TX_PARITY: begin
                    tx          <= 1'b1;
                    tx_stop_cnt <= 1'b0;
                    tx_state    <= TX_STOP;
                end
                TX_STOP: begin
                    if (last_stop) begin
                        if (!fifo_empty) begin
                            tx_word  <= fifo_data;
                            tx_shift <= fifo_data;
                            tx       <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_stop_cnt <= tx_stop_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    rx_state_t            rx_state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [3:0]           rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bad;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_par_bad    <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_valid <= 1'b0;
            if (tick16) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            rx_cnt   <= '0;
                            rx_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        // Line must still be low mid start bit, otherwise it was a glitch.
                        if (rx_cnt == 4'd7) begin
                            rx_cnt <= '0;
                            rx_bit <= '0;
                            rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == 4'd15) begin
                            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
                                rx_par_bad <= 1'b0;
                                if (PARITY != PARITY_NONE) rx_state <= RX_PARITY;
                                else                       rx_state <= RX_STOP;
                            end else begin
                                rx_bit <= rx_bit + 1'b1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == 4'd15) begin
                            rx_par_bad <= (rx_s != parity_bit(rx_shift));
                            rx_state   <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == 4'd15) begin
                            rx_data       <= rx_shift;
                            rx_parity_err <= rx_par_bad;
                            rx_frame_err  <= ~rx_s;
                            rx_valid      <= 1'b1;
                            rx_state      <= RX_IDLE;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench: default-rate TX framing plus a fast 7E2 instance for loopback, FIFO, RX error and reset cases.
module tb_uart_txrx;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Default instance: 8N1, RX_DIV = 54, bit period 864 clocks.
    logic       rst_def     = 1'b0;
    logic [7:0] def_tx_data = 8'h00;
    logic       def_wr      = 1'b0;
    logic       def_full, def_busy, def_tx, def_rx_valid, def_perr, def_ferr;
    logic [7:0] def_rx_data;

    uart_txrx u_def (
        .clk_in        (clk),
        .rst_n         (rst_def),
        .tx_data       (def_tx_data),
        .tx_wr_en      (def_wr),
        .tx_full       (def_full),
        .tx_busy       (def_busy),
        .tx            (def_tx),
        .rx            (1'b1),
        .rx_data       (def_rx_data),
        .rx_valid      (def_rx_valid),
        .rx_parity_err (def_perr),
        .rx_frame_err  (def_ferr)
    );

    // Fast instance: 7 data bits, even parity, 2 stop bits, RX_DIV = 4, bit period 64 clocks.
    logic       rst_fst     = 1'b0;
    logic [6:0] fst_tx_data = 7'h00;
    logic       fst_wr      = 1'b0;
    logic       loop        = 1'b0;
    logic       rx_drv      = 1'b1;
    logic       fst_full, fst_busy, fst_tx, fst_rx, fst_rx_valid, fst_perr, fst_ferr;
    logic [6:0] fst_rx_data;

    assign fst_rx = loop ? fst_tx : rx_drv;

    uart_txrx #(
        .CLK_FREQ      (6400),
        .BAUD          (100),
        .DATA_BITS     (7),
        .PARITY        (2),
        .STOP_BITS     (2),
        .TX_FIFO_DEPTH (4)
    ) u_fst (
        .clk_in        (clk),
        .rst_n         (rst_fst),
        .tx_data       (fst_tx_data),
        .tx_wr_en      (fst_wr),
        .tx_full       (fst_full),
        .tx_busy       (fst_busy),
        .tx            (fst_tx),
        .rx            (fst_rx),
        .rx_data       (fst_rx_data),
        .rx_valid      (fst_rx_valid),
        .rx_parity_err (fst_perr),
        .rx_frame_err  (fst_ferr)
    );

    logic [6:0] cap_data [64];
    logic       cap_perr [64];
    logic       cap_ferr [64];
    int         nvalid = 0;

    always @(negedge clk) begin
        if (fst_rx_valid && nvalid < 64) begin
            cap_data[nvalid] <= fst_rx_data;
            cap_perr[nvalid] <= fst_perr;
            cap_ferr[nvalid] <= fst_ferr;
            nvalid           <= nvalid + 1;
        end
    end

    typedef struct {
        logic [6:0] data;
        bit         flip_par;
        bit         bad_stop;
        logic [6:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_low(input bit fast, input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((fast ? fst_tx : def_tx) == 1'b0) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_fst_idle(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!fst_busy) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic reset_fst();
        @(negedge clk);
        rst_fst = 1'b0;
        repeat (2) @(negedge clk);
        rst_fst = 1'b1;
    endtask

    // Drives one 7E2 frame on rx_drv: start, data LSB first, parity, first stop, then idle.
    task automatic send_rx(input logic [6:0] d, input bit flip, input bit bad_stop);
        logic [9:0] bits;
        bits = {~bad_stop, (^d) ^ flip, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (64) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (128) @(negedge clk);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0, t1, base, lows;
        logic [7:0] a5;
        a5 = 8'hA5;

        vecs[0] = '{7'h55, 1'b0, 1'b0, 7'h55, 1'b0, 1'b0};
        vecs[1] = '{7'h2A, 1'b1, 1'b0, 7'h2A, 1'b1, 1'b0};
        vecs[2] = '{7'h3C, 1'b0, 1'b1, 7'h3C, 1'b0, 1'b1};
        vecs[3] = '{7'h7F, 1'b0, 1'b0, 7'h7F, 1'b0, 1'b0};
        vecs[4] = '{7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0};
        vecs[5] = '{7'h41, 1'b1, 1'b1, 7'h41, 1'b1, 1'b1};

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check("rst_def_tx", def_tx, 1);
        check("rst_def_busy", def_busy, 0);
        check("rst_def_full", def_full, 0);
        check("rst_def_valid", def_rx_valid, 0);
        check("rst_def_data", def_rx_data, 0);
        check("rst_def_errs", {def_perr, def_ferr}, 0);
        check("rst_fst_tx", fst_tx, 1);
        check("rst_fst_busy", fst_busy, 0);
        check("rst_fst_valid", fst_rx_valid, 0);
        check("rst_fst_data", fst_rx_data, 0);

        // Test 1: 0xA5 at the default rate.
        rst_def     = 1'b1;
        @(negedge clk);
        def_tx_data = a5;
        def_wr      = 1'b1;
        @(negedge clk);
        def_wr      = 1'b0;
        check("t1_busy_after_write", def_busy, 1);
        wait_low(1'b0, 2000, t0);
        check("t1_start_seen", t0 != -1, 1);
        if (t0 != -1) begin
            wait_until(t0 + 863);
            check("t1_start_last_clk", def_tx, 0);
            @(negedge clk);
            check("t1_bit0_first_clk", def_tx, 1);
            for (int k = 0; k < 8; k++) begin
                wait_until(t0 + 864 * (k + 1) + 432);
                check($sformatf("t1_bit%0d", k), def_tx, a5[k]);
            end
            wait_until(t0 + 9 * 864 + 432);
            check("t1_stop", def_tx, 1);
            wait_until(t0 + 8639);
            check("t1_busy_last_clk", def_busy, 1);
            @(negedge clk);
            check("t1_busy_drop", def_busy, 0);
        end

        // Test 2: loopback, two abutting 11-bit frames.
        loop = 1'b1;
        reset_fst();
        base        = nvalid;
        fst_tx_data = 7'h55;
        fst_wr      = 1'b1;
        @(negedge clk);
        fst_tx_data = 7'h2A;
        @(negedge clk);
        fst_wr      = 1'b0;
        wait_low(1'b1, 200, t0);
        check("t2_start_seen", t0 != -1, 1);
        if (t0 != -1) begin
            wait_until(t0 + 703);
            check("t2_stop_end", fst_tx, 1);
            @(negedge clk);
            check("t2_no_gap_start", fst_tx, 0);
            wait_fst_idle(2000, t1);
            check("t2_two_frames_len", t1 - t0, 1408);
        end
        repeat (8) @(negedge clk);
        check("t2_rx_count", nvalid - base, 2);
        check("t2_word0", cap_data[base], 7'h55);
        check("t2_word1", cap_data[base + 1], 7'h2A);
        check("t2_errs", {cap_perr[base], cap_ferr[base], cap_perr[base + 1], cap_ferr[base + 1]}, 0);

        // Test 3: six writes before the first tx_tick into a 4-deep FIFO.
        reset_fst();
        base = nvalid;
        for (int i = 0; i < 6; i++) begin
            fst_tx_data = 7'(8'h11 * (i + 1));
            fst_wr      = 1'b1;
            @(negedge clk);
            if (i == 2) check("t3_not_full_3", fst_full, 0);
            if (i == 3) check("t3_full_4", fst_full, 1);
        end
        fst_wr = 1'b0;
        check("t3_full_after_6", fst_full, 1);
        wait_low(1'b1, 200, t0);
        check("t3_start_seen", t0 != -1, 1);
        wait_fst_idle(6000, t1);
        check("t3_four_frames_len", t1 - t0, 4 * 704);
        repeat (1500) @(negedge clk);
        check("t3_rx_count", nvalid - base, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_word%0d", i), cap_data[base + i], 7'(8'h11 * (i + 1)));

        // Table: frames driven straight onto rx.
        loop = 1'b0;
        reset_fst();
        repeat (4) @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            base = nvalid;
            send_rx(vecs[v].data, vecs[v].flip_par, vecs[v].bad_stop);
            check($sformatf("vec%0d_count", v), nvalid - base, 1);
            check($sformatf("vec%0d_data", v), cap_data[base], vecs[v].exp_data);
            check($sformatf("vec%0d_perr", v), cap_perr[base], vecs[v].exp_perr);
            check($sformatf("vec%0d_ferr", v), cap_ferr[base], vecs[v].exp_ferr);
        end
        check("vec_data_holds", fst_rx_data, 7'h41);

        // Test 4: short low glitch, then a valid frame.
        repeat (128) @(negedge clk);
        base   = nvalid;
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_glitch_no_valid", nvalid - base, 0);
        check("t4_rx_idle", 32'(u_fst.rx_state), 32'(RX_IDLE));
        send_rx(7'h3C, 1'b0, 1'b0);
        check("t4_after_count", nvalid - base, 1);
        check("t4_after_data", cap_data[base], 7'h3C);
        check("t4_after_errs", {cap_perr[base], cap_ferr[base]}, 0);

        // Test 6: reset during data bit 3 with two words queued.
        loop = 1'b1;
        reset_fst();
        fst_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fst_tx_data = 7'(7'h61 + i);
            @(negedge clk);
        end
        fst_wr = 1'b0;
        wait_low(1'b1, 200, t0);
        check("t6_start_seen", t0 != -1, 1);
        wait_until(t0 + 4 * 64 + 32);
        check("t6_busy_before", fst_busy, 1);
        rst_fst = 1'b0;
        @(negedge clk);
        check("t6_rst_tx", fst_tx, 1);
        check("t6_rst_busy", fst_busy, 0);
        check("t6_rst_full", fst_full, 0);
        rst_fst = 1'b1;
        base    = nvalid;
        lows    = 0;
        for (int i = 0; i < 3 * 704; i++) begin
            @(negedge clk);
            if (!fst_tx) lows++;
        end
        check("t6_no_tx_activity", lows, 0);
        check("t6_busy_after", fst_busy, 0);
        check("t6_no_rx", nvalid - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
